arr_loader_16: RTL

ARR_LOADER_16 -- requirements
Module: arr_loader_16

---
 rtl/arr_loader_16_if.sv | 28 ++
 rtl/arr_loader_16.sv | 84 ++++++++
 2 files changed

// File: rtl/arr_loader_16_if.sv
// arr_loader_16_if -- handshake bundle between an element producer, the frame
// loader and the downstream min-finder.
//   in_valid/in_data/in_last : upstream beat (4-bit element, frame-end flag)
//   in_ready                 : loader accepts a beat this cycle
//   arr_out/count_out        : packed 16x4-bit frame and its real element count
//   arr_valid/arr_ack        : frame presented / frame consumed
// slave  : the loader's view.
// master : the environment's view (producer plus consumer).
interface arr_loader_16_if;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic [63:0] arr_out;
    logic [4:0]  count_out;
    logic        arr_valid;
    logic        arr_ack;

    modport slave (
        input  in_valid, in_data, in_last, arr_ack,
        output in_ready, arr_out, count_out, arr_valid
    );

    modport master (
        output in_valid, in_data, in_last, arr_ack,
        input  in_ready, arr_out, count_out, arr_valid
    );
endinterface

// File: rtl/arr_loader_16.sv
// arr_loader_16 -- collects up to 16 four-bit elements into a packed frame for
// a 16-input min-finder. Unused slots read as 4'hF so they never win a minimum.
// A frame closes on a beat with in_last or on the 16th beat, is presented until
// arr_ack, and the loader then returns to collecting with a cleared array.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : arr_loader_16_if.slave (see interface header for signal roles)
module arr_loader_16 (
    input  logic                 clk,
    input  logic                 rst_n,
    arr_loader_16_if.slave       bus
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    logic [4:0]  wr_ptr;
    logic [3:0]  elems [16];
    logic [4:0]  count_q;
    logic        valid_q;
    logic        ready_q;

    // NOTE: the element store is reset (to 4'hF) because padding must be
    // visible on arr_out from the first FILL cycle; it is only 64 flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FILL;
            wr_ptr  <= 5'd0;
            count_q <= 5'd0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            for (int k = 0; k < 16; k++) elems[k] <= 4'hF;
        end else begin
            case (state)
                FILL: begin
                    // in_ready is 1 throughout FILL, so in_valid alone accepts.
                    if (bus.in_valid) begin
                        elems[wr_ptr[3:0]] <= bus.in_data;
                        wr_ptr             <= wr_ptr + 5'd1;
                        // wr_ptr==15 here means this is the 16th beat.
                        if (bus.in_last || wr_ptr == 5'd15) begin
                            state   <= HOLD;
                            count_q <= wr_ptr + 5'd1;
                            valid_q <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (bus.arr_ack) begin
                        state   <= FILL;
                        wr_ptr  <= 5'd0;
                        count_q <= 5'd0;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        for (int k = 0; k < 16; k++) elems[k] <= 4'hF;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    // Pack the element store: element k lands on bits [4k+3:4k].
    // NOTE: the combinational packer assigns a default before the loop so no
    // bit can be left unassigned and inferred as a latch.
    always_comb begin
        bus.arr_out = '1;
        for (int k = 0; k < 16; k++) begin
            bus.arr_out[4*k +: 4] = elems[k];
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.arr_valid = valid_q;
    assign bus.count_out = count_q;

endmodule
